// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: reset/enable levels, bus widths
// and a small round-robin helper.
package regfile_wb_arbiter_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam int          RegAddrBusW  = 5;
    localparam int          RegBusW      = 32;
    localparam int          RegNum       = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    // Successor of a round-robin index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding slot: accept, drain on grant, flush, and the
// silent drop of writes to register 0.
module regfile_wb_arbiter_wb_slot
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = RegAddrBusW,
    parameter int DATA_W = RegBusW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept_s;

    // Next slot contents; flush beats everything, an accept beats a drain.
    always_comb begin
        full_d   = full_q;
        addr_d   = addr_q;
        data_d   = data_q;
        accept_s = in_valid & in_ready & ~flush;
        if (flush) begin
            full_d = 1'b0;
        end else if (accept_s) begin
            full_d = (in_addr != ADDR_W'(0));
            addr_d = in_addr;
            data_d = in_data;
        end else if (grant) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            full_q <= 1'b0;
            addr_q <= ADDR_W'(0);
            data_q <= DATA_W'(ZeroWord);
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one regfile write port among NUM_SRC writeback sources.
// Optional macro WB_PEND_MASK_EN enables the pending-write scoreboard output pend_mask.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int ADDR_W  = RegAddrBusW,
    parameter int DATA_W  = RegBusW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      busy,
    output logic [(2**ADDR_W)-1:0]    pend_mask
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] slot_full_s;
    logic [ADDR_W-1:0]  slot_addr_s [NUM_SRC];
    logic [DATA_W-1:0]  slot_data_s [NUM_SRC];
    logic [NUM_SRC-1:0] gnt_s;
    logic               gnt_any_s;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic [PTR_W:0]     scan_s;

    logic               rst_done_q, rst_done_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        regfile_wb_arbiter_wb_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (src_valid[i]),
            .in_ready (src_ready[i]),
            .in_addr  (src_addr[i*ADDR_W +: ADDR_W]),
            .in_data  (src_data[i*DATA_W +: DATA_W]),
            .grant    (gnt_s[i]),
            .full     (slot_full_s[i]),
            .addr     (slot_addr_s[i]),
            .data     (slot_data_s[i])
        );
    end

    // Ready is held low until the first edge after reset release.
    assign src_ready = rst_done_q ? (~slot_full_s | gnt_s) : {NUM_SRC{1'b0}};

    // Round-robin search: first full slot at or after rr_ptr, wrapping.
    always_comb begin
        gnt_s     = {NUM_SRC{1'b0}};
        gnt_any_s = 1'b0;
        gnt_idx_s = PTR_W'(0);
        scan_s    = (PTR_W + 1)'(0);
        for (int j = 0; j < NUM_SRC; j++) begin
            scan_s = {1'b0, rr_ptr_q} + (PTR_W + 1)'(j);
            if (scan_s >= (PTR_W + 1)'(NUM_SRC)) begin
                scan_s = scan_s - (PTR_W + 1)'(NUM_SRC);
            end else begin
                scan_s = scan_s;
            end
            if (!gnt_any_s && slot_full_s[scan_s[PTR_W-1:0]]) begin
                gnt_any_s                 = 1'b1;
                gnt_idx_s                 = scan_s[PTR_W-1:0];
                gnt_s[scan_s[PTR_W-1:0]]  = 1'b1;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Write stage and pointer update; a flush cancels this cycle's grant.
    always_comb begin
        rst_done_d = 1'b1;
        rr_ptr_d   = rr_ptr_q;
        we_d       = WriteDisable;
        waddr_d    = ADDR_W'(0);
        wdata_d    = DATA_W'(ZeroWord);
        if (gnt_any_s && !flush) begin
            rr_ptr_d = PTR_W'(rr_next(int'(gnt_idx_s), NUM_SRC));
            we_d     = WriteEnable;
            waddr_d  = slot_addr_s[gnt_idx_s];
            wdata_d  = slot_data_s[gnt_idx_s];
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Arbiter and write-stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rst_done_q <= 1'b0;
            rr_ptr_q   <= PTR_W'(0);
            we_q       <= WriteDisable;
            waddr_q    <= ADDR_W'(0);
            wdata_q    <= DATA_W'(ZeroWord);
        end else begin
            rst_done_q <= rst_done_d;
            rr_ptr_q   <= rr_ptr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = (|slot_full_s) | we_q;

`ifdef WB_PEND_MASK_EN
    // Destinations still owed a write: held slots plus the write stage; r0 never pends.
    always_comb begin
        pend_mask = {(2**ADDR_W){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (slot_full_s[i]) begin
                pend_mask[slot_addr_s[i]] = 1'b1;
            end else begin
                pend_mask = pend_mask;
            end
        end
        if (we_q) begin
            pend_mask[waddr_q] = 1'b1;
        end else begin
            pend_mask = pend_mask;
        end
        pend_mask[0] = 1'b0;
    end
`else
    assign pend_mask = {(2**ADDR_W){1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a queue-level reference model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] src_data;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            busy;
    logic [NR-1:0]   pend_mask;

    int n_checks;
    int n_fail;

    // Reference model state
    bit            m_full [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    int            m_ptr;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_done;
    logic [DW-1:0] tb_rf [NR];

    regfile_wb_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile fed by the DUT write port
    always @(posedge clk) begin
        if (rst && we && waddr != 5'd0) tb_rf[waddr] <= wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int j = 0; j < N; j++) begin
            if (m_full[(m_ptr + j) % N]) return (m_ptr + j) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_addr[i] = 5'd0;
            m_data[i] = 32'd0;
        end
        m_ptr = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_done = 1'b0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        g = model_grant();
        for (int i = 0; i < N; i++) r[i] = m_done && (!m_full[i] || g == i);
        return r;
    endfunction

    task automatic check_outputs();
        logic [NR-1:0] pm;
        bit anyfull;
        pm = '0;
        anyfull = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_full[i]) begin
                anyfull = 1'b1;
                pm[m_addr[i]] = 1'b1;
            end
        end
        if (m_we) pm[m_waddr] = 1'b1;
        pm[0] = 1'b0;
`ifndef WB_PEND_MASK_EN
        pm = '0;
`endif
        check("src_ready", 64'(src_ready), 64'(model_ready()));
        check("we", 64'(we), 64'(m_we));
        check("waddr", 64'(waddr), 64'(m_waddr));
        check("wdata", 64'(wdata), 64'(m_wdata));
        check("busy", 64'(busy), 64'(anyfull | m_we));
        check("pend_mask", 64'(pend_mask), 64'(pm));
    endtask

    task automatic model_edge();
        logic [N-1:0] rdy;
        int g;
        rdy = model_ready();
        g = model_grant();
        if (flush) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        end else begin
            if (g >= 0) begin
                m_we = 1'b1; m_waddr = m_addr[g]; m_wdata = m_data[g];
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && rdy[i] && src_addr[i*AW +: AW] != 5'd0) begin
                    m_full[i] = 1'b1;
                    m_addr[i] = src_addr[i*AW +: AW];
                    m_data[i] = src_data[i*DW +: DW];
                end
            end
        end
        m_done = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i] = v;
        src_addr[i*AW +: AW] = a;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic idle();
        src_valid = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_we", 64'(we), 64'd0);
        check("rst_ready", 64'(src_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pend", 64'(pend_mask), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        flush = 1'b0;
        src_valid = '0;
        src_addr = '0;
        src_data = '0;
        for (int r = 0; r < NR; r++) tb_rf[r] = 32'd0;
        #2;
        do_reset();

        // Idle after reset
        repeat (4) cycle();
        check("idle_ready", 64'(src_ready), 64'h7);

        // Single write latency
        drive(0, 1'b1, 5'd5, 32'h1234);
        cycle();
        idle();
        check("lat_no_we_n", 64'(we), 64'd0);
        cycle();
        check("lat_we", 64'(we), 64'd1);
        check("lat_waddr", 64'(waddr), 64'd5);
        check("lat_wdata", 64'(wdata), 64'h1234);
        cycle();
        check("lat_we_drop", 64'(we), 64'd0);
        check("lat_rf5", 64'(tb_rf[5]), 64'h1234);

        // Round-robin from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 1), $urandom());
        cycle();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 1), $urandom());
            cycle();
            check("rr_we", 64'(we), 64'd1);
            check("rr_order", 64'(waddr), 64'(k % 3 + 1));
        end
        idle();
        repeat (5) cycle();

        // Write to r0 is swallowed
        drive(1, 1'b1, 5'd0, 32'hDEAD);
        cycle();
        idle();
        check("r0_busy", 64'(busy), 64'd0);
        cycle();
        check("r0_we", 64'(we), 64'd0);

        // Pending mask for r9
        drive(2, 1'b1, 5'd9, 32'h99);
        cycle();
        idle();
`ifdef WB_PEND_MASK_EN
        check("pend9_slot", 64'(pend_mask[9]), 64'd1);
`else
        check("pend9_slot", 64'(pend_mask[9]), 64'd0);
`endif
        cycle();
        cycle();
        check("pend9_clear", 64'(pend_mask[9]), 64'd0);

        // Flush with a write in flight
        drive(1, 1'b1, 5'd7, 32'hA5);
        cycle();
        idle();
        drive(0, 1'b1, 5'd3, 32'h33);
        drive(2, 1'b1, 5'd4, 32'h44);
        cycle();
        idle();
        drive(0, 1'b1, 5'd6, 32'h66);
        flush = 1'b1;
        check("fl_inflight_we", 64'(we), 64'd1);
        check("fl_inflight_addr", 64'(waddr), 64'd7);
        check("fl_inflight_data", 64'(wdata), 64'hA5);
        cycle();
        idle();
        check("fl_busy", 64'(busy), 64'd0);
        repeat (2) cycle();

        // Random traffic with occasional flush and a mid-run reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                drive(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom());
            flush = ($urandom_range(0, 15) == 0);
            if (c == 200) begin
                do_reset();
            end else begin
                cycle();
            end
        end
        idle();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
